// File: rtl/adder_display.sv
// Purpose: shows a 4-bit adder's operands and results on a 4-digit, common-anode, multiplexed 7-segment display.
// Latency: an/seg/dp are registered, so each one follows digit position, snapshot and blank by 1 cycle.
// Backpressure: none; the inputs are sampled once per frame and no handshake is involved.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   a, b, sum           4-bit operands and adder sum (hex digits)
//   carry_out, overflow adder flags (carry is shown as 0/1; overflow blinks the sum digit's dp)
//   blank               1 = all digits dark, while internal scanning continues
//   an, seg, dp         active-low anodes (an[3] leftmost), segments {g,f,e,d,c,b,a} and decimal point
module adder_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sum,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Scan state
    logic [DW-1:0] div_cnt;
    logic [1:0]    digit_idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    // Values frozen for one whole frame
    logic [3:0]    a_s;
    logic [3:0]    b_s;
    logic [3:0]    sum_s;
    logic          carry_s;
    logic          ov_s;

    logic          tick;
    logic          frame_wrap;
    logic [3:0]    digit_val;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0:    f = 7'b1000000;
            4'h1:    f = 7'b1111001;
            4'h2:    f = 7'b0100100;
            4'h3:    f = 7'b0110000;
            4'h4:    f = 7'b0011001;
            4'h5:    f = 7'b0010010;
            4'h6:    f = 7'b0000010;
            4'h7:    f = 7'b1111000;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0010000;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b0000011;
            4'hC:    f = 7'b1000110;
            4'hD:    f = 7'b0100001;
            4'hE:    f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    assign tick       = (div_cnt == DIV_LAST);
    // The last slot of the leftmost digit ends the frame; this is the only
    // point where the snapshot may change, so a frame is never mixed.
    assign frame_wrap = tick && (digit_idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            digit_idx   <= 2'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
            a_s         <= 4'd0;
            b_s         <= 4'd0;
            sum_s       <= 4'd0;
            carry_s     <= 1'b0;
            ov_s        <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (frame_wrap) begin
                a_s     <= a;
                b_s     <= b;
                sum_s   <= sum;
                carry_s <= carry_out;
                ov_s    <= overflow;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        digit_val = sum_s;
        case (digit_idx)
            2'd0:    digit_val = sum_s;
            2'd1:    digit_val = {3'b000, carry_s};
            2'd2:    digit_val = b_s;
            default: digit_val = a_s;
        endcase

        an_nxt  = ~(4'b0001 << digit_idx);
        seg_nxt = hex7(digit_val);
        dp_nxt  = ~((digit_idx == 2'd0) && ov_s && blink_phase);

        // Blanking only masks the outputs; scanning state keeps moving so the
        // display resumes at the correct position.
        if (blank) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule
